// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin issue of operand pairs onto one shared 9-stage multiplier
// Tags {valid, id} ride alongside the multiplier so each product returns to its requester.

module mult8x8 (
    input  logic        clk,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    // No reset and no valid qualifier: the scheduler owns all validity tracking.
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [11:0] r_lo;
    logic [11:0] r_hi;
    logic [15:0] r_dly [0:6];

    always_ff @(posedge clk) begin
        r_a      <= a;
        r_b      <= b;
        r_lo     <= 12'(r_a * r_b[3:0]);
        r_hi     <= 12'(r_a * r_b[7:4]);
        r_dly[0] <= {4'b0000, r_lo} + {r_hi, 4'b0000};
        for (int s = 1; s < 7; s++) begin
            r_dly[s] <= r_dly[s-1];
        end
    end

    assign p = r_dly[6];
endmodule

module mult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_p,
    output logic                 busy,
    output logic [15:0]          issue_cnt
);
    logic [ID_W-1:0]              r_last;
    logic [15:0]                  r_cnt;
    logic [LATENCY-1:0]           r_tag_v;
    logic [LATENCY-1:0][ID_W-1:0] r_tag_id;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W-1:0]    w_idx;
    logic               w_hs;
    logic [7:0]         w_mul_a;
    logic [7:0]         w_mul_b;
    logic [15:0]        w_mul_p;

    // Search starts one past the last winner, so a fresh reset favours requester 0.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_idx      = '0;
        w_hs       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
            if (!w_hs && en && req_valid[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_grant_id     = w_idx;
                w_hs           = 1'b1;
            end
        end
    end

    assign req_ready = w_grant;
    assign w_mul_a   = w_hs ? req_a[{w_grant_id, 3'b000} +: 8] : 8'd0;
    assign w_mul_b   = w_hs ? req_b[{w_grant_id, 3'b000} +: 8] : 8'd0;

    mult8x8 u_mult (
        .clk (clk),
        .a   (w_mul_a),
        .b   (w_mul_b),
        .p   (w_mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= ID_W'(NUM_REQ - 1);
            r_cnt    <= 16'd0;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            if (w_hs) begin
                r_last <= w_grant_id;
                r_cnt  <= r_cnt + 16'd1;
            end
            r_tag_v  <= {r_tag_v[LATENCY-2:0], w_hs};
            r_tag_id <= {r_tag_id[LATENCY-2:0], w_grant_id};
        end
    end

    assign rsp_valid = r_tag_v[LATENCY-1];
    assign rsp_id    = r_tag_id[LATENCY-1];
    assign rsp_p     = w_mul_p;
    assign busy      = |r_tag_v;
    assign issue_cnt = r_cnt;
endmodule
